int_arbiter: RTL and testbench

INT_ARBITER -- requirements
Module: int_arbiter

---
 rtl/int_arbiter.sv | 99 +++++++++
 tb/tb_int_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/int_arbiter.sv
// Four-source interrupt arbiter: rising-edge capture into a pending register,
// per-source mask, fixed priority (0 highest), REQ/ACK/DONE handshake to the CPU.
module int_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] irqIn,
  input  logic       maskWr,
  input  logic [7:0] maskIn,
  input  logic       intAck,
  input  logic       intDone,
  output logic       intReq,
  output logic [1:0] intVec,
  output logic [3:0] pendOut,
  output logic [7:0] maskOut
);

  localparam int unsigned NSRC = 4;
  localparam int unsigned VW   = 2;
  localparam int unsigned MW   = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [NSRC-1:0] irq_prev, pend, mask;
  logic [NSRC-1:0] eligible, pend_set, pend_clr;
  logic [VW-1:0]   vec_reg, vec_next, prio_idx;
  logic            int_req_next;
  logic            unused_mask_hi;

  assign unused_mask_hi = ^maskIn[MW-1:NSRC];

  assign pend_set = irqIn & ~irq_prev;
  assign eligible = pend & mask;

  // Descending scan so the lowest eligible index is the one left standing.
  always_comb begin
    prio_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (eligible[i]) prio_idx = VW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // The grant is frozen in vec_reg from IDLE->REQ until the FSM is back in IDLE.
  always_comb begin
    state_next = state;
    vec_next   = vec_reg;
    pend_clr   = '0;
    case (state)
      IDLE: begin
        if (|eligible) begin
          vec_next   = prio_idx;
          state_next = REQ;
        end
      end
      REQ: begin
        if (intAck) begin
          pend_clr   = NSRC'(1) << vec_reg;
          state_next = SERVICE;
        end
      end
      SERVICE: begin
        if (intDone) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    int_req_next = (state_next == REQ);
  end

  // A new edge on the bit being acknowledged outranks the clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_prev <= '0;
      pend     <= '0;
      mask     <= '0;
      vec_reg  <= '0;
      intReq   <= 1'b0;
    end else begin
      irq_prev <= irqIn;
      pend     <= (pend & ~pend_clr) | pend_set;
      if (maskWr) mask <= maskIn[NSRC-1:0];
      vec_reg  <= vec_next;
      intReq   <= int_req_next;
    end
  end

  assign intVec  = vec_reg;
  assign pendOut = pend;
  assign maskOut = {{(MW - NSRC){1'b0}}, mask};

endmodule

// File: tb/tb_int_arbiter.sv
// Self-checking bench for int_arbiter: expected grant order is queued when
// interrupt edges are driven and compared when the DUT raises intReq.
module tb_int_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] irqIn;
  logic       maskWr;
  logic [7:0] maskIn;
  logic       intAck;
  logic       intDone;
  logic       intReq;
  logic [1:0] intVec;
  logic [3:0] pendOut;
  logic [7:0] maskOut;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned exp_q[$];

  int_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .irqIn   (irqIn),
    .maskWr  (maskWr),
    .maskIn  (maskIn),
    .intAck  (intAck),
    .intDone (intDone),
    .intReq  (intReq),
    .intVec  (intVec),
    .pendOut (pendOut),
    .maskOut (maskOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mask(input logic [7:0] m);
    maskWr = 1'b1;
    maskIn = m;
    tick();
    maskWr = 1'b0;
    maskIn = 8'hA0;
  endtask

  task automatic pulse(input logic [3:0] bits);
    irqIn = bits;
    tick();
    irqIn = 4'b0;
  endtask

  task automatic expect_req(input string tag);
    int unsigned exp_vec;
    int unsigned waited;
    waited = 0;
    while (!intReq && waited < 8) begin
      tick();
      waited++;
    end
    check({tag, "_req"}, 32'(intReq), 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_underflow"}, 32'd1, 32'd0);
    end else begin
      exp_vec = exp_q.pop_front();
      check({tag, "_vec"}, 32'(intVec), exp_vec);
    end
  endtask

  task automatic ack_done(input string tag);
    intAck = 1'b1;
    tick();
    intAck = 1'b0;
    check({tag, "_ack_drop"}, 32'(intReq), 32'd0);
    intDone = 1'b1;
    tick();
    intDone = 1'b0;
  endtask

  initial begin
    rst     = 1'b0;
    irqIn   = 4'b0;
    maskWr  = 1'b0;
    maskIn  = 8'h0;
    intAck  = 1'b0;
    intDone = 1'b0;
    tick();
    tick();
    check("rst_req", 32'(intReq), 32'd0);
    check("rst_vec", 32'(intVec), 32'd0);
    check("rst_pend", 32'(pendOut), 32'd0);
    check("rst_mask", 32'(maskOut), 32'd0);
    rst = 1'b1;
    tick();

    // Single source, exact latency, upper mask bits ignored
    write_mask(8'hFF);
    check("mask_rb", 32'(maskOut), 32'h0F);
    irqIn = 4'b0100;
    exp_q.push_back(2);
    tick();
    irqIn = 4'b0;
    check("lat_pend", 32'(pendOut), 32'b0100);
    check("lat_req0", 32'(intReq), 32'd0);
    tick();
    check("lat_req1", 32'(intReq), 32'd1);
    expect_req("s2");
    ack_done("s2");
    check("s2_pend_clr", 32'(pendOut), 32'd0);
    check("s2_vec_hold", 32'(intVec), 32'd2);

    // Two simultaneous sources: priority order 1 then 3
    exp_q.push_back(1);
    exp_q.push_back(3);
    pulse(4'b1010);
    check("pri_pend", 32'(pendOut), 32'b1010);
    expect_req("pri1");
    ack_done("pri1");
    check("pri_gap", 32'(intReq), 32'd0);
    expect_req("pri3");
    ack_done("pri3");

    // Masked source pends but does not request until enabled
    write_mask(8'h00);
    pulse(4'b0001);
    check("msk_pend", 32'(pendOut), 32'b0001);
    tick();
    tick();
    check("msk_noreq", 32'(intReq), 32'd0);
    exp_q.push_back(0);
    write_mask(8'h01);
    check("msk_req_e1", 32'(intReq), 32'd0);
    tick();
    check("msk_req_e2", 32'(intReq), 32'd1);
    expect_req("msk0");
    ack_done("msk0");

    // New edge on the acknowledged source in the ack cycle: set wins
    write_mask(8'h0F);
    exp_q.push_back(1);
    exp_q.push_back(1);
    pulse(4'b0010);
    expect_req("race_a");
    irqIn  = 4'b0010;
    intAck = 1'b1;
    tick();
    irqIn  = 4'b0;
    intAck = 1'b0;
    check("race_pend", 32'(pendOut), 32'b0010);
    check("race_req", 32'(intReq), 32'd0);
    intDone = 1'b1;
    tick();
    intDone = 1'b0;
    expect_req("race_b");
    ack_done("race_b");

    // Request held through mask clear and stray done; ack+done is ack only
    exp_q.push_back(2);
    pulse(4'b0100);
    expect_req("hold");
    write_mask(8'h00);
    check("hold_mask0", 32'(intReq), 32'd1);
    check("hold_vec", 32'(intVec), 32'd2);
    intDone = 1'b1;
    tick();
    intDone = 1'b0;
    check("hold_done_ign", 32'(intReq), 32'd1);
    intAck  = 1'b1;
    intDone = 1'b1;
    tick();
    intAck  = 1'b0;
    intDone = 1'b0;
    check("ackdone_req", 32'(intReq), 32'd0);
    check("ackdone_pend", 32'(pendOut), 32'd0);
    write_mask(8'h0F);
    pulse(4'b1000);
    tick();
    tick();
    check("nest_block", 32'(intReq), 32'd0);
    check("nest_pend", 32'(pendOut), 32'b1000);
    exp_q.push_back(3);
    intDone = 1'b1;
    tick();
    intDone = 1'b0;
    expect_req("nest3");
    ack_done("nest3");

    // Asynchronous reset during SERVICE, then level-high source after release
    exp_q.push_back(1);
    pulse(4'b0010);
    expect_req("ar");
    intAck = 1'b1;
    tick();
    intAck = 1'b0;
    check("ar_vec_pre", 32'(intVec), 32'd1);
    rst   = 1'b0;
    irqIn = 4'b1000;
    #1;
    check("ar_req", 32'(intReq), 32'd0);
    check("ar_vec", 32'(intVec), 32'd0);
    check("ar_pend", 32'(pendOut), 32'd0);
    check("ar_mask", 32'(maskOut), 32'd0);
    tick();
    tick();
    check("ar_pend_hold", 32'(pendOut), 32'd0);
    rst = 1'b1;
    tick();
    check("ar_first_edge", 32'(pendOut), 32'b1000);
    exp_q.push_back(3);
    write_mask(8'h08);
    expect_req("lvl");
    ack_done("lvl");
    tick();
    tick();
    check("lvl_no_reset", 32'(pendOut), 32'd0);
    check("lvl_no_req", 32'(intReq), 32'd0);
    irqIn = 4'b0;
    tick();
    exp_q.push_back(3);
    pulse(4'b1000);
    check("lvl_reedge", 32'(pendOut), 32'b1000);
    expect_req("lvl2");
    ack_done("lvl2");

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
